mc_ram: RTL

Parametrised multi-cycle single-port RAM and the successor to the fixed 256x8 lab RAM. It accepts one read or write request at a time and completes it after a programmable access latency. Read data is presented on a dedicated output, qualified by a valid strobe and held for a programmable number of cycles. It sits behind the lab CPU/testbench bus as the generic memory model for later labs, and adds reset, busy/done signalling, width/depth generics and selectable power-on contents.

---
 rtl/mc_ram_if.sv | 27 ++
 rtl/mc_ram.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mc_ram_if.sv
// Request/response bundle for mc_ram: one request channel (rd/wr/addr/wdata)
// and the status/data returned by the memory.
interface mc_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              wdone;

  // Requester side: issues commands, observes completion.
  modport master (
    output rd, wr, addr, wdata,
    input  rdata, rvalid, busy, wdone
  );

  // Memory side: accepts commands, reports completion.
  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, rvalid, busy, wdone
  );
endinterface

// File: rtl/mc_ram.sv
// mc_ram: multi-cycle single-port RAM. One read or write is accepted at a
// time in IDLE and completes after LATENCY cycles; read data is then held
// valid for HOLD cycles, and busy stays high for HOLD cycles after a commit.
//
// Power-on contents: the storage array holds each word XOR-ed with its
// power-on image (init_word). An array that powers up all-zero therefore
// reads back as the selected INIT_MODE contents, with no load sequence, and
// reset never disturbs it.
module mc_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 2**ADDR_W,
  parameter int LATENCY   = 2,
  parameter int HOLD      = 2,
  parameter int INIT_MODE = 1
) (
  input logic   clk,
  input logic   rst,
  mc_ram_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RWAIT = 3'd1,
    RHOLD = 3'd2,
    WWAIT = 3'd3,
    WHOLD = 3'd4
  } state_t;

  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  // Power-on value of a word: zeros, or a descending ramp from DEPTH-1.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    if (INIT_MODE == 1) begin
      return DATA_W'(DEPTH - 1 - int'(a));
    end
    return '0;
  endfunction

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_busy;
  logic              r_wdone;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_mem_q;

  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_ok;
  logic              w_a_ok;
  logic              w_we;

  // In IDLE the array is addressed straight from the bus so that the word
  // is already registered one edge after acceptance (needed for LATENCY=1);
  // afterwards the latched address keeps it pointed at the same word.
  assign w_rd_addr = (r_state == IDLE) ? bus.addr : r_addr;

  // Range checks only exist when the address space is larger than DEPTH.
  generate
    if (DEPTH < 2**ADDR_W) begin : g_partial
      localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
      assign w_rd_ok = ({1'b0, w_rd_addr} < DEPTH_L);
      assign w_a_ok  = ({1'b0, r_addr} < DEPTH_L);
    end else begin : g_full
      assign w_rd_ok = 1'b1;
      assign w_a_ok  = 1'b1;
    end
  endgenerate

  // Commit on the last WWAIT edge; out-of-range writes are dropped. The rst
  // term keeps a reset coincident with the commit edge from writing.
  assign w_we = (r_state == WWAIT) && (r_cnt == 8'd0) && w_a_ok && !rst;

  // Storage array with registered read port (no reset, contents survive rst).
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_addr] <= r_wdata ^ init_word(r_addr);
    end
    if (w_rd_ok) begin
      r_mem_q <= r_mem[w_rd_addr];
    end
  end

  // Control FSM: request acceptance, latency/hold timing, registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_wdone  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Read has priority; a simultaneous write is discarded.
          if (bus.rd) begin
            r_addr  <= bus.addr;
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
            r_state <= RWAIT;
          end else if (bus.wr) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= LAT_M1;
            r_busy  <= 1'b1;
            r_state <= WWAIT;
          end
        end
        RWAIT: begin
          if (r_cnt == 8'd0) begin
            r_rdata  <= w_a_ok ? (r_mem_q ^ init_word(r_addr)) : '0;
            r_rvalid <= 1'b1;
            r_cnt    <= HOLD_M1;
            r_state  <= RHOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RHOLD: begin
          if (r_cnt == 8'd0) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        WWAIT: begin
          if (r_cnt == 8'd0) begin
            r_wdone <= 1'b1;
            r_cnt   <= HOLD_M1;
            r_state <= WHOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        WHOLD: begin
          r_wdone <= 1'b0;
          if (r_cnt == 8'd0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = r_busy;
  assign bus.wdone  = r_wdone;

endmodule
